instr_sequencer: RTL

Program-driven issue controller for the 3-bit-opcode processor core. Holds a small instruction program loaded over a write port. On start, it issues the instructions one at a time on the processor's instr/reg1/reg2/reg3/imm fields. It gates each issue on the processor's done handshake. Replaces bench-side hand sequencing and sits directly in front of the processor.

---
 rtl/seq_pkg.sv | 44 ++++
 rtl/seq_prog_mem.sv | 26 ++
 rtl/instr_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and field layout for the instruction sequencer.
// Instruction word: {opcode[33:31], r1[30:26], r2[25:21], r3[20:16], imm[15:0]}.
package seq_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned INSTR_W = 34;

  localparam int unsigned OP_LSB  = 31;
  localparam int unsigned R1_LSB  = 26;
  localparam int unsigned R2_LSB  = 21;
  localparam int unsigned R3_LSB  = 16;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    Op000 = 3'b000,
    Op001 = 3'b001,
    Op010 = 3'b010,
    Op011 = 3'b011,
    Op100 = 3'b100,
    Op101 = 3'b101,
    Op110 = 3'b110,
    Op111 = 3'b111
  } opcode_e;

  // Field order matches the packed word so a plain cast unpacks it.
  typedef struct packed {
    opcode_e          op;
    logic [REG_W-1:0] r1;
    logic [REG_W-1:0] r2;
    logic [REG_W-1:0] r3;
    logic [IMM_W-1:0] imm;
  } instr_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StWaitDone,
    StHalted
  } state_e;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: DEPTH x INSTR_W register file, synchronous write, combinational read.
module seq_prog_mem
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Issues a loaded program to the processor one instruction at a time, gated on done.
// Optional single-step gating when SEQ_STEP_EN is defined (adds i_step / i_step_mode).
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ACK_TIMEOUT = 4,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_prog_we,
  input  logic [AW-1:0]      i_prog_addr,
  input  logic [INSTR_W-1:0] i_prog_wdata,
  input  logic [AW:0]        i_prog_len,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_done,
`ifdef SEQ_STEP_EN
  input  logic               i_step,
  input  logic               i_step_mode,
`endif
  output logic [OP_W-1:0]    o_instr,
  output logic [REG_W-1:0]   o_reg1,
  output logic [REG_W-1:0]   o_reg2,
  output logic [REG_W-1:0]   o_reg3,
  output logic [IMM_W-1:0]   o_imm,
  output logic               o_issue,
  output logic               o_busy,
  output logic               o_halted,
  output logic [AW-1:0]      o_pc,
  output logic [AW:0]        o_retired
);

  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  state_e             r_state, w_state_d;
  logic [AW:0]        r_len, w_len_d;
  logic [AW-1:0]      r_pc, w_pc_d;
  logic [AW:0]        r_retired, w_retired_d;
  logic [CW-1:0]      r_ack_cnt, w_ack_cnt_d;
  instr_t             r_fields, w_fields_d;
  logic               r_issue, w_issue_d;
  logic               w_complete, w_can_issue, w_last, w_idle_like, w_mem_we;
  logic [INSTR_W-1:0] w_rdata;

  assign w_idle_like = (r_state == StIdle) || (r_state == StHalted);
  assign w_mem_we    = i_prog_we && w_idle_like;
  assign w_last      = ({1'b0, r_pc} + {{AW{1'b0}}, 1'b1}) == r_len;

  seq_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .i_clk   (i_clk),
    .i_we    (w_mem_we),
    .i_waddr (i_prog_addr),
    .i_wdata (i_prog_wdata),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

`ifdef SEQ_STEP_EN
  // Each step pulse is consumed by one issue; step must drop before it can arm again.
  logic r_step_used;

  assign w_can_issue = i_done && (!i_step_mode || (i_step && !r_step_used));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step_used <= 1'b0;
    end else if (w_issue_d && i_step_mode) begin
      r_step_used <= 1'b1;
    end else if (!i_step) begin
      r_step_used <= 1'b0;
    end
  end
`else
  assign w_can_issue = i_done;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_len_d     = r_len;
    w_pc_d      = r_pc;
    w_retired_d = r_retired;
    w_ack_cnt_d = r_ack_cnt;
    w_fields_d  = r_fields;
    w_issue_d   = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      StIdle, StHalted: begin
        if (i_start) begin
          w_len_d     = i_prog_len;
          w_pc_d      = '0;
          w_retired_d = '0;
          w_state_d   = (i_prog_len == '0) ? StHalted : StIssue;
        end
      end
      StIssue: begin
        if (i_abort) begin
          w_state_d = StIdle;
        end else if (w_can_issue) begin
          w_fields_d  = instr_t'(w_rdata);
          w_issue_d   = 1'b1;
          w_ack_cnt_d = '0;
          w_state_d   = StWaitAck;
        end
      end
      StWaitAck: begin
        if (i_abort) begin
          w_state_d = StIdle;
        end else if (!i_done) begin
          w_state_d = StWaitDone;
        end else if (r_ack_cnt == CW'(ACK_TIMEOUT)) begin
          // done never dropped: treat as a single-cycle instruction
          w_complete = 1'b1;
        end else begin
          w_ack_cnt_d = r_ack_cnt + 1'b1;
        end
      end
      StWaitDone: begin
        if (i_abort) begin
          w_state_d = StIdle;
        end else if (i_done) begin
          w_complete = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_complete) begin
      w_retired_d = r_retired + 1'b1;
      if (w_last) begin
        w_state_d = StHalted;
      end else begin
        w_pc_d    = r_pc + 1'b1;
        w_state_d = StIssue;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len     <= '0;
      r_pc      <= '0;
      r_retired <= '0;
      r_ack_cnt <= '0;
      r_fields  <= '0;
      r_issue   <= 1'b0;
    end else begin
      r_len     <= w_len_d;
      r_pc      <= w_pc_d;
      r_retired <= w_retired_d;
      r_ack_cnt <= w_ack_cnt_d;
      r_fields  <= w_fields_d;
      r_issue   <= w_issue_d;
    end
  end

  always_comb begin
    o_busy   = !w_idle_like;
    o_halted = (r_state == StHalted);
  end

  assign o_instr   = r_fields.op;
  assign o_reg1    = r_fields.r1;
  assign o_reg2    = r_fields.r2;
  assign o_reg3    = r_fields.r3;
  assign o_imm     = r_fields.imm;
  assign o_issue   = r_issue;
  assign o_pc      = r_pc;
  assign o_retired = r_retired;

endmodule
